fsm_fib_ctrl: RTL
=================

# fsm_fib_ctrl

Parametrised Fibonacci sequencing controller for the 16-bit CPU datapath. It drives the register-file enables, the left/right operand mux selects, the immediate path, the ALU opcode and the ALU output tristate (`buff_en`) so the datapath generates terms F0..F(n-1) in three rotating registers. A new run starts on a `start` request, may be stopped with `abort`, and reports completion with a one-cycle `done` pulse.

## Interface
- `DATA_W`, 16: width of the immediate bus.
- `NUM_REGS`, 16: register count; width of the one-hot `enable`.
- `SEL_W`, 5: operand mux select width.
- `OPC_W`, 8: opcode width.
- `OP_ADD`, 8'h05: ALU add opcode.
- `REG_BASE`, 1: first of the three working registers (REG_BASE..REG_BASE+2); must satisfy REG_BASE+2 < NUM_REGS and REG_BASE ≥ 1.
- `MAX_TERMS`, 24: largest accepted term count (F23 = 28657 fits in 16 bits).
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  synchronous stop; return to IDLE.
- `n_terms`  in  8  number of terms to generate; latched on an accepted `start`.
- `immediate`  out  DATA_W  immediate operand.
- `enable`  out  NUM_REGS  one-hot register write enable.
- `control1`  out  SEL_W  left mux select (value k selects register k).
- `control2`  out  SEL_W  right mux select.
- `imm_control`  out  1  1 replaces the right operand with `immediate`.
- `opcode`  out  OPC_W  ALU operation.
- `buff_en`  out  1  ALU output tristate enable.
- `busy`  out  1  run in progress (LOAD0, LOAD1, STEP).
- `done`  out  1  one-cycle completion pulse.
- `term_idx`  out  8  index of the term written this cycle.
- `result_sel`  out  SEL_W  register holding the most recent term.

## Operation
- States: IDLE, LOAD0, LOAD1, STEP, DONE.
- Datapath rule: register 0 reads as zero. A load uses `opcode`=OP_ADD, `control1`=0, `imm_control`=1 and `immediate`=value.
- **IDLE:** all datapath outputs are 0.
  - If `start`=1, latch `n_eff` = min(`n_terms`, MAX_TERMS).
  - `n_eff`=0 goes to DONE; otherwise go to LOAD0.
- **LOAD0:** write 0 into REG_BASE.
  - `enable` bit REG_BASE = 1, `buff_en`=1, `term_idx`=0.
  - Go to DONE if `n_eff`=1, else go to LOAD1.
- **LOAD1:** write 1 into REG_BASE+1 (`term_idx`=1).
  - Clear `rot` to 0 and the step counter to 0.
  - Go to DONE if `n_eff`=2, else go to STEP.
- **STEP:** drive the addition.
  - `control1` = REG_BASE+`rot`, `control2` = REG_BASE+(`rot`+1) mod 3, `imm_control`=0, `opcode`=OP_ADD, `buff_en`=1.
  - `enable` is the one-hot of dest = REG_BASE+(`rot`+2) mod 3.
  - `term_idx` = step+2.
  - Each cycle: `rot` = (`rot`+1) mod 3 (wraps 2→0) and step increments.
  - After the step with `term_idx` = `n_eff`−1, go to DONE.
- **DONE:** `done`=1 for one cycle with all datapath outputs 0, then go to IDLE.
- `result_sel` is registered; it updates to the dest of every write and holds in IDLE. After a run it names the register holding F(`n_eff`−1).
- `start` while busy or in DONE is ignored.
- `abort` in any non-IDLE state forces IDLE on the next edge, suppresses `done`, and leaves `result_sel` holding its last value. `abort` has priority over `start` in the same cycle.

## Timing
- State, `rot`, counters, `n_eff` and `result_sel` are flops on the rising `clk` edge. Datapath outputs are Moore, decoded from the state register.
- Asynchronous reset (`reset`=0) gives state IDLE, and `rot`, counters, `n_eff`, `result_sel` = 0. Every output is then 0: `immediate`, `enable`, `control1`, `control2`, `imm_control`, `opcode`, `buff_en`, `busy`, `done`, `term_idx`.
- The datapath commits a write on the edge that ends the cycle in which `enable`/`buff_en` are asserted.
- Latency for `n_eff` ≥ 2, with `start` sampled at edge 0:
  - LOAD0 in cycle 1, LOAD1 in cycle 2.
  - STEP in cycles 3..`n_eff`.
  - `done` in cycle `n_eff`+1.
  - Total = `n_eff`+2 cycles from `start` to `done`.
- A new `start` is accepted no earlier than the first IDLE cycle after DONE.
- Reset mid-run takes effect immediately: outputs go to 0 without waiting for a clock edge.

## Structure
- Shared package `cpu_ctrl_pkg`: `OP_ADD` and the other ALU opcodes, the state encoding (IDLE=0, LOAD0=1, LOAD1=2, STEP=3, DONE=4, 4-bit), and the operand-select widths.
- One sub-module, `rot3_ptr`: mod-3 rotation counter with clear/advance. It outputs `rot`, (`rot`+1) mod 3 and (`rot`+2) mod 3.
- The one-hot `enable` decode stays inline.

## Test plan
- Reset with `start` held high and `reset` pulsed low mid-STEP → all outputs read 0 immediately; state IDLE.
- `n_terms`=12 with a behavioural datapath model → `done` in cycle 13; REG_BASE+2 = 89; `result_sel`=3; per-cycle `term_idx` runs 0..11 and `enable` walks 2,4,8,2,4,8,…
- `n_terms`=0, 1 and 2 →
  - 0: `done` in cycle 1.
  - 1: r1=0, `done` in cycle 2.
  - 2: r2=1, `done` in cycle 3.
- `n_terms`=200 → clamped to 24; `done` in cycle 25; final value 28657 in REG_BASE+2 (`result_sel`=3).
- `abort` in cycle 5 of a 12-term run → IDLE in cycle 6, no `done` pulse; `result_sel` holds the cycle-5 dest.
- `start` re-asserted during STEP → ignored; `start` in the IDLE cycle after DONE → new run with LOAD0 on the next cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control FSMs: ALU opcodes, FSM state encoding
// and operand-select widths.
package cpu_ctrl_pkg;

    localparam int OPC_WIDTH = 8;
    localparam int SEL_WIDTH = 5;
    localparam int STATE_W   = 4;

    localparam logic [OPC_WIDTH-1:0] ALU_NOP = 8'h00;
    localparam logic [OPC_WIDTH-1:0] ALU_MOV = 8'h01;
    localparam logic [OPC_WIDTH-1:0] ALU_AND = 8'h02;
    localparam logic [OPC_WIDTH-1:0] ALU_OR  = 8'h03;
    localparam logic [OPC_WIDTH-1:0] ALU_XOR = 8'h04;
    localparam logic [OPC_WIDTH-1:0] ALU_ADD = 8'h05;
    localparam logic [OPC_WIDTH-1:0] ALU_SUB = 8'h06;

    localparam logic [STATE_W-1:0] S_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] S_LOAD0 = 4'd1;
    localparam logic [STATE_W-1:0] S_LOAD1 = 4'd2;
    localparam logic [STATE_W-1:0] S_STEP  = 4'd3;
    localparam logic [STATE_W-1:0] S_DONE  = 4'd4;

    function automatic logic [1:0] mod3_inc(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/rot3_ptr.sv
// Mod-3 rotation pointer for the three working Fibonacci registers; exposes the
// current slot and the next two slots in rotation order.
module rot3_ptr
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] rot,
    output logic [1:0] rot_p1,
    output logic [1:0] rot_p2
);

    logic [1:0] rot_q;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rot_q <= 2'd0;
        end else if (clear) begin
            rot_q <= 2'd0;
        end else if (advance) begin
            rot_q <= mod3_inc(rot_q);
        end
    end

    assign rot    = rot_q;
    assign rot_p1 = mod3_inc(rot_q);
    assign rot_p2 = mod3_inc(rot_p1);

endmodule

// File: rtl/fsm_fib_ctrl.sv
// Fibonacci sequencing controller: drives register enables, operand selects and
// ALU controls so the datapath builds F0..F(n-1) in three rotating registers.
module fsm_fib_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                NUM_REGS  = 16,
    parameter int                SEL_W     = SEL_WIDTH,
    parameter int                OPC_W     = OPC_WIDTH,
    parameter logic [OPC_W-1:0]  OP_ADD    = OPC_W'(ALU_ADD),
    parameter int                REG_BASE  = 1,
    parameter int                MAX_TERMS = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          n_terms,
    output logic [DATA_W-1:0]   immediate,
    output logic [NUM_REGS-1:0] enable,
    output logic [SEL_W-1:0]    control1,
    output logic [SEL_W-1:0]    control2,
    output logic                imm_control,
    output logic [OPC_W-1:0]    opcode,
    output logic                buff_en,
    output logic                busy,
    output logic                done,
    output logic [7:0]          term_idx,
    output logic [SEL_W-1:0]    result_sel
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [7:0]         n_eff_q;
    logic [7:0]         step_q;
    logic [7:0]         n_clamp;
    logic [7:0]         term_cur;
    logic [SEL_W-1:0]   result_sel_q;
    logic [SEL_W-1:0]   dest_sel;
    logic [1:0]         rot;
    logic [1:0]         rot_p1;
    logic [1:0]         rot_p2;
    logic               accept;
    logic               writing;

    rot3_ptr u_rot (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == S_LOAD1),
        .advance (state_q == S_STEP),
        .rot     (rot),
        .rot_p1  (rot_p1),
        .rot_p2  (rot_p2)
    );

    assign n_clamp = (n_terms > 8'(MAX_TERMS)) ? 8'(MAX_TERMS) : n_terms;
    assign accept  = (state_q == S_IDLE) && start && !abort;
    assign writing = (state_q == S_LOAD0) || (state_q == S_LOAD1) || (state_q == S_STEP);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        term_cur = 8'd0;
        dest_sel = '0;
        case (state_q)
            S_LOAD0: begin
                term_cur = 8'd0;
                dest_sel = SEL_W'(REG_BASE);
            end
            S_LOAD1: begin
                term_cur = 8'd1;
                dest_sel = SEL_W'(REG_BASE + 1);
            end
            S_STEP: begin
                term_cur = step_q + 8'd2;
                dest_sel = SEL_W'(REG_BASE) + SEL_W'(rot_p2);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (n_clamp == 8'd0) ? S_DONE : S_LOAD0;
            S_LOAD0: state_d = (n_eff_q == 8'd1) ? S_DONE : S_LOAD1;
            S_LOAD1: state_d = (n_eff_q == 8'd2) ? S_DONE : S_STEP;
            S_STEP:  if (term_cur == n_eff_q - 8'd1) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides any transition and drops the run without a done pulse.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            n_eff_q      <= 8'd0;
            step_q       <= 8'd0;
            result_sel_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                n_eff_q <= n_clamp;
            end
            if (state_q == S_LOAD1) begin
                step_q <= 8'd0;
            end else if (state_q == S_STEP) begin
                step_q <= step_q + 8'd1;
            end
            if (writing) begin
                result_sel_q <= dest_sel;
            end
        end
    end

    // Moore datapath decode; loads add the immediate to register 0, which reads as zero.
    always_comb begin
        immediate   = '0;
        enable      = '0;
        control1    = '0;
        control2    = '0;
        imm_control = 1'b0;
        opcode      = '0;
        buff_en     = 1'b0;
        term_idx    = 8'd0;
        if (writing) begin
            enable   = NUM_REGS'(1) << dest_sel;
            opcode   = OP_ADD;
            buff_en  = 1'b1;
            term_idx = term_cur;
        end
        case (state_q)
            S_LOAD0: imm_control = 1'b1;
            S_LOAD1: begin
                imm_control = 1'b1;
                immediate   = DATA_W'(1);
            end
            S_STEP: begin
                control1 = SEL_W'(REG_BASE) + SEL_W'(rot);
                control2 = SEL_W'(REG_BASE) + SEL_W'(rot_p1);
            end
            default: ;
        endcase
    end

    assign busy       = writing;
    assign done       = (state_q == S_DONE);
    assign result_sel = result_sel_q;

endmodule
